// File: rtl/kypd_scan_ctrl.sv
// PmodKYPD 4x4 scan sequencer: column strobing, per-frame key decode,
// frame-level debounce and a valid/ready key-event port.
module kypd_scan_ctrl #(
  parameter int unsigned COL_PERIOD = 100000,
  parameter int unsigned SETTLE     = 8,
  parameter int unsigned DEBOUNCE   = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] Row,
  output logic [3:0] Col,
  output logic [3:0] key_code,
  output logic       key_valid,
  input  logic       key_ready,
  output logic       key_held,
  output logic       key_drop
);

  localparam int unsigned TW = (COL_PERIOD > 1) ? $clog2(COL_PERIOD) : 1;
  localparam int unsigned CW = $clog2(DEBOUNCE + 1);
  localparam logic [TW-1:0] TLAST = TW'(COL_PERIOD - 1);
  localparam logic [TW-1:0] TSAMP = TW'(SETTLE);
  localparam logic [CW-1:0] CMAX  = CW'(DEBOUNCE);
  localparam logic [CW-1:0] CONE  = CW'(1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DEB_P   = 2'd1,
    PRESSED = 2'd2,
    DEB_R   = 2'd3
  } state_t;

  // Key legend indexed by {column, row}; row 0 is Row[3].
  function automatic logic [3:0] key_map(input logic [1:0] c, input logic [1:0] r);
    logic [3:0] k;
    k = 4'h0;
    case ({c, r})
      4'h0: k = 4'h1;
      4'h1: k = 4'h4;
      4'h2: k = 4'h7;
      4'h3: k = 4'h0;
      4'h4: k = 4'h2;
      4'h5: k = 4'h5;
      4'h6: k = 4'h8;
      4'h7: k = 4'hF;
      4'h8: k = 4'h3;
      4'h9: k = 4'h6;
      4'hA: k = 4'h9;
      4'hB: k = 4'hE;
      4'hC: k = 4'hA;
      4'hD: k = 4'hB;
      4'hE: k = 4'hC;
      4'hF: k = 4'hD;
      default: k = 4'h0;
    endcase
    return k;
  endfunction

  logic [TW-1:0] timer;
  logic [1:0]    col_idx;
  logic [1:0]    acc_hits;
  logic [3:0]    acc_code;

  logic [3:0]    low;
  logic [2:0]    row_pop;
  logic [1:0]    row_idx;
  logic [2:0]    hits_sum;
  logic [1:0]    merged_hits;
  logic [3:0]    merged_code;
  logic          sample;
  logic          frame_done;
  logic          frame_key;

  state_t        state, state_d;
  logic [3:0]    cand, cand_d;
  logic [CW-1:0] cnt, cnt_d, cnt_inc;
  logic          match;
  logic          press_evt;
  logic          accept;

  // Column timer; Col rotates one-cold in step with col_idx at each wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer   <= '0;
      col_idx <= 2'd0;
      Col     <= 4'b0111;
    end else if (timer == TLAST) begin
      timer   <= '0;
      col_idx <= col_idx + 2'd1;
      Col     <= {Col[0], Col[3:1]};
    end else begin
      timer   <= timer + TW'(1);
    end
  end

  // Merge the current column's row sample into the running frame result.
  always_comb begin
    low     = ~Row;
    row_pop = 3'(low[0]) + 3'(low[1]) + 3'(low[2]) + 3'(low[3]);
    row_idx = 2'd0;
    if (low[3])      row_idx = 2'd0;
    else if (low[2]) row_idx = 2'd1;
    else if (low[1]) row_idx = 2'd2;
    else if (low[0]) row_idx = 2'd3;
    hits_sum    = 3'(acc_hits) + row_pop;
    merged_hits = (hits_sum > 3'd1) ? 2'd2 : hits_sum[1:0];
    merged_code = (row_pop == 3'd1) ? key_map(col_idx, row_idx) : acc_code;
    sample      = (timer == TSAMP);
    frame_done  = sample && (col_idx == 2'd3);
    frame_key   = frame_done && (merged_hits == 2'd1);
  end

  // acc_hits saturates at 2, meaning "more than one key seen this frame".
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_hits <= 2'd0;
      acc_code <= 4'h0;
    end else if (frame_done) begin
      acc_hits <= 2'd0;
      acc_code <= 4'h0;
    end else if (sample) begin
      acc_hits <= merged_hits;
      acc_code <= merged_code;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cand  <= 4'h0;
      cnt   <= '0;
    end else begin
      state <= state_d;
      cand  <= cand_d;
      cnt   <= cnt_d;
    end
  end

  // Debounce FSM: advances at most once per frame, on the frame result.
  always_comb begin
    state_d   = state;
    cand_d    = cand;
    cnt_d     = cnt;
    press_evt = 1'b0;
    match     = frame_key && (merged_code == cand);
    cnt_inc   = (cnt == CMAX) ? cnt : cnt + CONE;
    if (frame_done) begin
      case (state)
        IDLE: begin
          if (frame_key) begin
            cand_d = merged_code;
            cnt_d  = CONE;
            if (CMAX == CONE) begin
              state_d   = PRESSED;
              press_evt = 1'b1;
            end else begin
              state_d = DEB_P;
            end
          end
        end
        DEB_P: begin
          if (match) begin
            cnt_d = cnt_inc;
            if (cnt_inc == CMAX) begin
              state_d   = PRESSED;
              press_evt = 1'b1;
            end
          end else if (frame_key) begin
            cand_d = merged_code;
            cnt_d  = CONE;
          end else begin
            state_d = IDLE;
          end
        end
        PRESSED: begin
          if (!match) begin
            cnt_d   = CONE;
            state_d = (CMAX == CONE) ? IDLE : DEB_R;
          end
        end
        DEB_R: begin
          if (match) begin
            state_d = PRESSED;
          end else begin
            cnt_d = cnt_inc;
            if (cnt_inc == CMAX) state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign accept = key_valid && key_ready;

  // Event port: a press that finds the previous event still unaccepted is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_code  <= 4'h0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
      key_drop  <= 1'b0;
    end else begin
      key_drop <= 1'b0;
      key_held <= (state_d == PRESSED) || (state_d == DEB_R);
      if (press_evt) begin
        if (!key_valid || accept) begin
          key_code  <= cand_d;
          key_valid <= 1'b1;
        end else begin
          key_drop  <= 1'b1;
        end
      end else if (accept) begin
        key_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_kypd_scan_ctrl.sv
// Directed bench for kypd_scan_ctrl with a small keypad model driving Row from Col.
module tb_kypd_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_ready;
  logic       key_held;
  logic       key_drop;

  logic [3:0] kp [4];

  int n_chk  = 0;
  int n_pass = 0;

  int         n_rise = 0;
  int         n_drop = 0;
  int         n_acc  = 0;
  int         n_code_chg = 0;
  logic       prev_valid = 1'b0;
  logic [3:0] prev_code  = 4'h0;
  logic [3:0] last_code  = 4'h0;

  kypd_scan_ctrl #(
    .COL_PERIOD(16),
    .SETTLE    (4),
    .DEBOUNCE  (3)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .Row      (row),
    .Col      (col),
    .key_code (key_code),
    .key_valid(key_valid),
    .key_ready(key_ready),
    .key_held (key_held),
    .key_drop (key_drop)
  );

  always #5 clk = ~clk;

  // Keypad: the strobed column's switches pull their rows low.
  always_comb begin
    case (col)
      4'b0111: row = kp[0];
      4'b1011: row = kp[1];
      4'b1101: row = kp[2];
      4'b1110: row = kp[3];
      default: row = 4'hF;
    endcase
  end

  // Event monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (key_valid && !prev_valid) begin
      n_rise    <= n_rise + 1;
      last_code <= key_code;
    end
    if (key_drop) n_drop <= n_drop + 1;
    if (key_valid && key_ready) n_acc <= n_acc + 1;
    if (key_valid && prev_valid && (key_code != prev_code)) n_code_chg <= n_code_chg + 1;
    prev_valid <= key_valid;
    prev_code  <= key_code;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_none();
    for (int i = 0; i < 4; i++) kp[i] = 4'hF;
  endtask

  task automatic set_all_low();
    for (int i = 0; i < 4; i++) kp[i] = 4'h0;
  endtask

  task automatic set_key(input int c, input int r);
    logic [3:0] m;
    set_none();
    m = 4'b1000 >> r;
    kp[c] = ~m;
  endtask

  int r0, d0, a0;

  initial begin
    rst_n     = 1'b0;
    key_ready = 1'b0;
    set_none();
    step(3);
    chk("rst_col",   32'(col),       32'h7);
    chk("rst_valid", 32'(key_valid), 32'd0);
    chk("rst_held",  32'(key_held),  32'd0);
    chk("rst_drop",  32'(key_drop),  32'd0);
    chk("rst_code",  32'(key_code),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Column stepping, one column per 16 cycles
    step(15);
    chk("col_e15", 32'(col), 32'h7);
    step(1);
    chk("col_e16", 32'(col), 32'hB);
    step(16);
    chk("col_e32", 32'(col), 32'hD);
    step(16);
    chk("col_e48", 32'(col), 32'hE);
    step(16);
    chk("col_e64", 32'(col), 32'h7);

    // Hold '5' for 3 frames with consumer ready
    key_ready = 1'b1;
    r0 = n_rise;
    set_key(1, 1);
    step(180);
    chk("t1_valid_early", 32'(key_valid), 32'd0);
    step(1);
    chk("t1_valid", 32'(key_valid), 32'd1);
    chk("t1_code",  32'(key_code),  32'h5);
    chk("t1_held",  32'(key_held),  32'd1);
    step(1);
    chk("t1_valid_fall", 32'(key_valid), 32'd0);
    step(10);
    set_none();
    step(180);
    chk("t1_held_deb_r", 32'(key_held), 32'd1);
    step(1);
    chk("t1_held_rel", 32'(key_held), 32'd0);
    step(11);
    chk("t1_events", 32'(n_rise - r0), 32'd1);
    chk("t1_last_code", 32'(last_code), 32'h5);

    // Bounce: 2 frames '5', 1 NONE, 3 frames '5'
    r0 = n_rise;
    set_key(1, 1);
    step(128);
    set_none();
    step(64);
    set_key(1, 1);
    step(64);
    chk("t2_held_mid",  32'(key_held),  32'd0);
    chk("t2_valid_mid", 32'(key_valid), 32'd0);
    step(116);
    chk("t2_valid_early", 32'(key_valid), 32'd0);
    step(1);
    chk("t2_valid", 32'(key_valid), 32'd1);
    chk("t2_code",  32'(key_code),  32'h5);
    step(11);
    set_none();
    step(192);
    chk("t2_events", 32'(n_rise - r0), 32'd1);

    // Candidate switch inside debounce: '5' x2 then '8' x3
    r0 = n_rise;
    set_key(1, 1);
    step(128);
    set_key(1, 2);
    step(181);
    chk("t2b_valid", 32'(key_valid), 32'd1);
    chk("t2b_code",  32'(key_code),  32'h8);
    step(11);
    set_none();
    step(192);
    chk("t2b_events", 32'(n_rise - r0), 32'd1);

    // Consumer stalled: 'A', release, '2' -> second press dropped
    key_ready = 1'b0;
    r0 = n_rise;
    d0 = n_drop;
    a0 = n_acc;
    set_key(3, 0);
    step(192);
    set_none();
    step(192);
    set_key(1, 0);
    step(192);
    set_none();
    step(192);
    chk("t3_valid",  32'(key_valid),    32'd1);
    chk("t3_code",   32'(key_code),     32'hA);
    chk("t3_drops",  32'(n_drop - d0),  32'd1);
    chk("t3_events", 32'(n_rise - r0),  32'd1);
    key_ready = 1'b1;
    step(1);
    chk("t3_valid_fall", 32'(key_valid), 32'd0);
    chk("t3_accepts", 32'(n_acc - a0), 32'd1);
    step(63);

    // Multi-press: every row low on every column
    r0 = n_rise;
    set_all_low();
    for (int f = 0; f < 5; f++) begin
      step(64);
      chk($sformatf("t4_held_f%0d", f), 32'(key_held), 32'd0);
    end
    set_none();
    step(64);
    chk("t4_events", 32'(n_rise - r0), 32'd0);
    chk("t4_valid",  32'(key_valid),   32'd0);

    // Reset while an event is pending and the FSM is releasing
    key_ready = 1'b0;
    set_key(1, 1);
    step(192);
    set_none();
    step(74);
    chk("t5_pre_valid", 32'(key_valid), 32'd1);
    chk("t5_pre_held",  32'(key_held),  32'd1);
    chk("t5_pre_code",  32'(key_code),  32'h5);
    rst_n = 1'b0;
    #1;
    chk("t5_col",   32'(col),       32'h7);
    chk("t5_valid", 32'(key_valid), 32'd0);
    chk("t5_held",  32'(key_held),  32'd0);
    chk("t5_drop",  32'(key_drop),  32'd0);
    chk("t5_code",  32'(key_code),  32'd0);
    step(2);
    @(negedge clk);
    rst_n = 1'b1;
    step(128);
    chk("t5_post_valid", 32'(key_valid), 32'd0);
    chk("t5_post_held",  32'(key_held),  32'd0);

    chk("code_stable", 32'(n_code_chg), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
